// File: rtl/nanorv32_exec_ctrl.sv
// Multi-cycle execution sequencer for nanorv32: fetch/exec/mem/trap control,
// commit gating, trap cause capture and retired-instruction counting.
module nanorv32_exec_ctrl #(
  parameter int DMEM_TIMEOUT = 16,
  parameter int INSTRET_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 inst_load,
  output logic                 dec_valid,
  input  logic                 illegal_instruction,
  input  logic                 datamem_read_sel,
  input  logic                 datamem_write_sel,
  output logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_update,
  output logic                 rf_we_gate,
  input  logic                 irq_req,
  output logic                 irq_ack,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_TRAP} state_e;

  localparam int               CNT_W    = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
  localparam bit               TO_EN    = (DMEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(DMEM_TIMEOUT - 1) : '0;

  localparam logic [1:0] C_ILL = 2'd1;
  localparam logic [1:0] C_BUS = 2'd2;
  localparam logic [1:0] C_IRQ = 2'd3;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           cause_q, cause_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    instret_d  = instret_q;
    commit     = 1'b0;
    imem_req   = 1'b0;
    inst_load  = 1'b0;
    dec_valid  = 1'b0;
    dmem_req   = 1'b0;
    pc_update  = 1'b0;
    rf_we_gate = 1'b0;
    irq_ack    = 1'b0;
    trap       = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          inst_load = 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        dec_valid = 1'b1;
        if (illegal_instruction) begin
          state_d = S_TRAP;
          cause_d = C_ILL;
        end else if (datamem_read_sel || datamem_write_sel) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else begin
          commit = 1'b1;
        end
      end
      S_MEM: begin
        // Decoder selects stay valid here since instruction_r is not reloaded.
        dmem_req  = 1'b1;
        dec_valid = 1'b1;
        if (dmem_ready) begin
          commit = 1'b1;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d = S_TRAP;
          cause_d = C_BUS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TRAP: begin
        trap    = 1'b1;
        irq_ack = (cause_q == C_IRQ);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // Interrupts are only taken at an instruction boundary, after commit.
    if (commit) begin
      pc_update  = 1'b1;
      rf_we_gate = 1'b1;
      instret_d  = instret_q + 1'b1;
      if (irq_req) begin
        state_d = S_TRAP;
        cause_d = C_IRQ;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_nanorv32_exec_ctrl.sv
// Directed bench for nanorv32_exec_ctrl: each task walks the sequencer cycle by
// cycle and compares the control outputs against hand-derived vectors.
module tb_nanorv32_exec_ctrl;
  localparam int TO = 16;

  logic        clk, rst;
  logic        imem_req, imem_ready, inst_load, dec_valid;
  logic        illegal_instruction, datamem_read_sel, datamem_write_sel;
  logic        dmem_req, dmem_ready, pc_update, rf_we_gate;
  logic        irq_req, irq_ack, trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;
  logic [31:0] base;
  logic [7:0]  outs;

  int n_cmp = 0;
  int n_bad = 0;

  // {imem_req, inst_load, dec_valid, dmem_req, pc_update, rf_we_gate, irq_ack, trap}
  assign outs = {imem_req, inst_load, dec_valid, dmem_req, pc_update, rf_we_gate, irq_ack, trap};

  nanorv32_exec_ctrl #(.DMEM_TIMEOUT(TO), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ready(imem_ready), .inst_load(inst_load),
    .dec_valid(dec_valid), .illegal_instruction(illegal_instruction),
    .datamem_read_sel(datamem_read_sel), .datamem_write_sel(datamem_write_sel),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_update(pc_update), .rf_we_gate(rf_we_gate),
    .irq_req(irq_req), .irq_ack(irq_ack), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst = 1'b1; imem_ready = 0; illegal_instruction = 0; datamem_read_sel = 0;
    datamem_write_sel = 0; dmem_ready = 0; irq_req = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (outs !== 8'b0000_0000) begin n_bad++; $display("FAIL reset_outs: got %b want %b", outs, 8'b0); end
    n_cmp++; if (instret !== 32'd0) begin n_bad++; $display("FAIL reset_instret: got %0d want 0", instret); end
    n_cmp++; if (trap_cause !== 2'd0) begin n_bad++; $display("FAIL reset_cause: got %0d want 0", trap_cause); end
  endtask

  task automatic test_alu_stream;
    imem_ready = 1'b1; rst = 1'b0;
    #1;
    n_cmp++; if (outs !== 8'b0000_0000) begin n_bad++; $display("FAIL alu_idle: got %b want %b", outs, 8'b0); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (outs !== 8'b1100_0000) begin n_bad++; $display("FAIL alu_fetch%0d: got %b want 11000000", i, outs); end
      @(negedge clk); #1;
      n_cmp++; if (outs !== 8'b0010_1100) begin n_bad++; $display("FAIL alu_exec%0d: got %b want 00101100", i, outs); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (instret !== 32'd3) begin n_bad++; $display("FAIL alu_instret: got %0d want 3", instret); end
  endtask

  task automatic test_fetch_wait;
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (outs !== 8'b1000_0000) begin n_bad++; $display("FAIL fw_wait%0d: got %b want 10000000", i, outs); end
      @(negedge clk);
    end
    imem_ready = 1'b1; #1;
    n_cmp++; if (outs !== 8'b1100_0000) begin n_bad++; $display("FAIL fw_ready: got %b want 11000000", outs); end
    @(negedge clk);
    imem_ready = 1'b0; #1;
    n_cmp++; if (outs !== 8'b0010_1100) begin n_bad++; $display("FAIL fw_exec: got %b want 00101100", outs); end
    @(negedge clk); #1;
    n_cmp++; if (outs !== 8'b1000_0000) begin n_bad++; $display("FAIL fw_no_dv2: got %b want 10000000", outs); end
  endtask

  task automatic test_load;
    base = instret;
    datamem_read_sel = 1'b1; imem_ready = 1'b1; #1;
    n_cmp++; if (outs !== 8'b1100_0000) begin n_bad++; $display("FAIL ld_fetch: got %b want 11000000", outs); end
    @(negedge clk);
    imem_ready = 1'b0; #1;
    n_cmp++; if (outs !== 8'b0010_0000) begin n_bad++; $display("FAIL ld_exec: got %b want 00100000", outs); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (outs !== 8'b0011_0000) begin n_bad++; $display("FAIL ld_wait%0d: got %b want 00110000", i, outs); end
      @(negedge clk);
    end
    dmem_ready = 1'b1; #1;
    n_cmp++; if (outs !== 8'b0011_1100) begin n_bad++; $display("FAIL ld_done: got %b want 00111100", outs); end
    @(negedge clk);
    dmem_ready = 1'b0; datamem_read_sel = 1'b0; #1;
    n_cmp++; if (outs !== 8'b1000_0000) begin n_bad++; $display("FAIL ld_refetch: got %b want 10000000", outs); end
    n_cmp++; if (instret !== base + 32'd1) begin n_bad++; $display("FAIL ld_instret: got %0d want %0d", instret, base + 32'd1); end
  endtask

  task automatic test_illegal;
    base = instret;
    imem_ready = 1'b1; illegal_instruction = 1'b1; #1;
    n_cmp++; if (outs !== 8'b1100_0000) begin n_bad++; $display("FAIL ill_fetch: got %b want 11000000", outs); end
    @(negedge clk);
    imem_ready = 1'b0; irq_req = 1'b1; #1;
    n_cmp++; if (outs !== 8'b0010_0000) begin n_bad++; $display("FAIL ill_exec: got %b want 00100000", outs); end
    @(negedge clk);
    irq_req = 1'b0; illegal_instruction = 1'b0; #1;
    n_cmp++; if (outs !== 8'b0000_0001) begin n_bad++; $display("FAIL ill_trap: got %b want 00000001", outs); end
    n_cmp++; if (trap_cause !== 2'd1) begin n_bad++; $display("FAIL ill_cause: got %0d want 1", trap_cause); end
    @(negedge clk); #1;
    n_cmp++; if (outs !== 8'b1000_0000) begin n_bad++; $display("FAIL ill_refetch: got %b want 10000000", outs); end
    n_cmp++; if (instret !== base) begin n_bad++; $display("FAIL ill_instret: got %0d want %0d", instret, base); end
  endtask

  task automatic test_timeout;
    datamem_write_sel = 1'b1; imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0; #1;
    n_cmp++; if (outs !== 8'b0010_0000) begin n_bad++; $display("FAIL to_exec: got %b want 00100000", outs); end
    @(negedge clk);
    for (int i = 0; i < TO; i++) begin
      #1;
      n_cmp++; if (outs !== 8'b0011_0000) begin n_bad++; $display("FAIL to_mem%0d: got %b want 00110000", i, outs); end
      @(negedge clk);
    end
    datamem_write_sel = 1'b0; #1;
    n_cmp++; if (outs !== 8'b0000_0001) begin n_bad++; $display("FAIL to_trap: got %b want 00000001", outs); end
    n_cmp++; if (trap_cause !== 2'd2) begin n_bad++; $display("FAIL to_cause: got %0d want 2", trap_cause); end
    @(negedge clk);
    // Ready arriving in the last allowed MEM cycle must commit, not trap.
    base = instret;
    datamem_read_sel = 1'b1; imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < TO - 1; i++) @(negedge clk);
    dmem_ready = 1'b1; #1;
    n_cmp++; if (outs !== 8'b0011_1100) begin n_bad++; $display("FAIL to_edge_commit: got %b want 00111100", outs); end
    @(negedge clk);
    dmem_ready = 1'b0; datamem_read_sel = 1'b0; #1;
    n_cmp++; if (outs !== 8'b1000_0000) begin n_bad++; $display("FAIL to_edge_notrap: got %b want 10000000", outs); end
    n_cmp++; if (trap_cause !== 2'd2) begin n_bad++; $display("FAIL to_cause_held: got %0d want 2", trap_cause); end
    n_cmp++; if (instret !== base + 32'd1) begin n_bad++; $display("FAIL to_edge_instret: got %0d want %0d", instret, base + 32'd1); end
  endtask

  task automatic test_irq;
    base = instret;
    irq_req = 1'b1; imem_ready = 1'b1; #1;
    n_cmp++; if (outs !== 8'b1100_0000) begin n_bad++; $display("FAIL irq_fetch: got %b want 11000000", outs); end
    @(negedge clk);
    imem_ready = 1'b0; #1;
    n_cmp++; if (outs !== 8'b0010_1100) begin n_bad++; $display("FAIL irq_exec: got %b want 00101100", outs); end
    @(negedge clk);
    irq_req = 1'b0; #1;
    n_cmp++; if (outs !== 8'b0000_0011) begin n_bad++; $display("FAIL irq_trap: got %b want 00000011", outs); end
    n_cmp++; if (trap_cause !== 2'd3) begin n_bad++; $display("FAIL irq_cause: got %0d want 3", trap_cause); end
    n_cmp++; if (instret !== base + 32'd1) begin n_bad++; $display("FAIL irq_instret: got %0d want %0d", instret, base + 32'd1); end
    @(negedge clk); #1;
    n_cmp++; if (outs !== 8'b1000_0000) begin n_bad++; $display("FAIL irq_refetch: got %b want 10000000", outs); end
  endtask

  task automatic test_reset_mid_mem;
    datamem_read_sel = 1'b1; imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (outs !== 8'b0011_0000) begin n_bad++; $display("FAIL rm_mem: got %b want 00110000", outs); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (outs !== 8'b0000_0000) begin n_bad++; $display("FAIL rm_outs: got %b want 00000000", outs); end
    n_cmp++; if (instret !== 32'd0) begin n_bad++; $display("FAIL rm_instret: got %0d want 0", instret); end
    n_cmp++; if (trap_cause !== 2'd0) begin n_bad++; $display("FAIL rm_cause: got %0d want 0", trap_cause); end
    @(negedge clk);
    rst = 1'b0; datamem_read_sel = 1'b0; #1;
    n_cmp++; if (outs !== 8'b0000_0000) begin n_bad++; $display("FAIL rm_idle: got %b want 00000000", outs); end
    @(negedge clk); #1;
    n_cmp++; if (outs !== 8'b1000_0000) begin n_bad++; $display("FAIL rm_fetch: got %b want 10000000", outs); end
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_fetch_wait();
    test_load();
    test_illegal();
    test_timeout();
    test_irq();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nanorv32_exec_ctrl.md
Name: nanorv32_exec_ctrl

Overview:
Multi-cycle sequencer for the nanorv32 core. It controls instruction fetch, qualifies the decoder output and waits for data memory. It also gates PC and register-file updates and raises traps for illegal instructions, data-bus timeouts and interrupts. It sits between the instruction/data memory handshakes and the decoder, and counts retired instructions.

Parameters:
DMEM_TIMEOUT, 16, max MEM-state cycles without dmem_ready before bus-error trap; 0 disables timeout
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous active-high reset
imem_req  output  1  instruction fetch request
imem_ready  input  1  fetch data valid this cycle
inst_load  output  1  load fetched word into instruction_r
dec_valid  output  1  decoder outputs qualified this cycle
illegal_instruction  input  1  from decoder
datamem_read_sel  input  1  decoder: instruction reads data memory
datamem_write_sel  input  1  decoder: instruction writes data memory
dmem_req  output  1  data memory access request
dmem_ready  input  1  data access complete this cycle
pc_update  output  1  commit pc_next
rf_we_gate  output  1  enables decoder regfile_write_sel
irq_req  input  1  level interrupt request
irq_ack  output  1  one-cycle interrupt acknowledge
trap  output  1  one-cycle trap pulse
trap_cause  output  2  0 none, 1 illegal, 2 bus error, 3 irq; held until next trap
instret  output  INSTRET_W  retired-instruction count

Behaviour:
- Reset (asynchronous, any state): state=IDLE, timeout counter=0, instret=0, trap_cause=0, all 1-bit outputs 0.
- States: IDLE, FETCH, EXEC, MEM, TRAP. All 1-bit outputs are combinational from state plus inputs. trap_cause and instret are registered.
- IDLE: outputs 0; next FETCH unconditionally. The first imem_req is asserted in the second cycle after reset release.
- FETCH: imem_req=1. If imem_ready=1: inst_load=1 in the same cycle, next EXEC. Else stay; imem_req held.
- EXEC: dec_valid=1 for exactly one cycle per fetched instruction. Priority:
  1. illegal_instruction=1 -> next TRAP, cause 1; pc_update=0, rf_we_gate=0.
  2. datamem_read_sel|datamem_write_sel -> next MEM, counter cleared; pc_update=0, rf_we_gate=0.
  3. otherwise -> pc_update=1, rf_we_gate=1, instret+1. Next TRAP cause 3 if irq_req=1, else FETCH.
- MEM: dmem_req=1, dec_valid=1; the decoder selects stay stable because instruction_r is unchanged.
  - dmem_ready=1 -> pc_update=1, rf_we_gate=1, instret+1. Next TRAP cause 3 if irq_req, else FETCH.
  - No ready and counter==DMEM_TIMEOUT-1 (DMEM_TIMEOUT>0) -> next TRAP, cause 2; pc_update=0, rf_we_gate=0.
  - Otherwise counter+1, stay.
  - dmem_ready in the timeout cycle wins: normal completion, no trap.
- TRAP: trap=1 and irq_ack=(trap_cause==3) for one cycle; no pc_update. Next FETCH. The trap vector PC is selected externally from trap.
- trap_cause is updated on the transition into TRAP.
- irq_req is sampled only at instruction commit, never in FETCH, IDLE or TRAP. An illegal instruction has priority over a pending irq.
- instret wraps modulo 2^INSTRET_W with no saturation.
- Reset mid-MEM or mid-FETCH aborts immediately; requests drop asynchronously with rst.
- Minimum latency: ALU instruction is 2 cycles (FETCH with ready, EXEC); load/store is 3 cycles (FETCH, EXEC, MEM with ready).

Test Plan:
- Reset release with imem_ready=1 and a legal ALU opcode -> IDLE 1 cycle, then FETCH/EXEC alternating; pc_update every 2nd cycle; instret=3 after 6 cycles.
- Fetch with imem_ready low 4 cycles -> imem_req held 5 cycles, inst_load exactly on the ready cycle, single dec_valid pulse.
- Load (datamem_read_sel=1) with dmem_ready after 3 wait cycles -> dmem_req high 4 cycles, pc_update and rf_we_gate together on the 4th, instret+1.
- illegal_instruction=1 in EXEC -> next cycle trap=1 with trap_cause=1; no pc_update; instret unchanged; then FETCH.
- DMEM_TIMEOUT=16, dmem_ready never asserted -> exactly 16 MEM cycles, then trap with cause=2. Repeat with dmem_ready on cycle 16 -> normal commit, no trap.
- irq_req high during FETCH and EXEC of an ALU instruction -> instruction commits, then trap with cause=3 and irq_ack pulse. Assert rst mid-MEM -> dmem_req=0 immediately; instret=0.
